// File: rtl/router_pkg.sv
// Shared router types: port count and the state encodings of the output-stage merge.
package router_pkg;

    localparam int unsigned NUM_OUT_PORTS = 4;

    typedef enum logic [0:0] {
        IN_IDLE,
        IN_ACK_HI
    } merge_in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ_HI,
        OUT_WAIT_LO
    } merge_out_state_t;

    function automatic logic [1:0] rr_advance(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr, wrapping mod 4.
module rr_arbiter4
    import router_pkg::*;
(
    input  logic [NUM_OUT_PORTS-1:0] req,
    input  logic [1:0]               rr_ptr,
    output logic [NUM_OUT_PORTS-1:0] grant,
    output logic [1:0]               grant_idx
);

    logic [1:0] pos;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            pos = rr_ptr + 2'(i);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/output_merge4.sv
// 4:1 router output stage: round-robin accept of 4-phase input channels into a FIFO, 4-phase output.
// Define OUTPUT_MERGE4_SYNC_IN_EN to pass in_req and out_ack through 2-flop synchronizers.
module output_merge4
    import router_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_OUT_PORTS-1:0]        in_req,
    output logic [NUM_OUT_PORTS-1:0]        in_ack,
    input  logic [NUM_OUT_PORTS-1:0][N-1:0] in_data,
    output logic                            out_req,
    input  logic                            out_ack,
    output logic [N-1:0]                    out_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NUM_OUT_PORTS-1:0] req_s;
    logic                     ack_s;

`ifdef OUTPUT_MERGE4_SYNC_IN_EN
    logic [NUM_OUT_PORTS-1:0] req_m;
    logic                     ack_m;

    // Bundled data needs no synchronizer: it is held stable until the ack returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_m <= '0;
            req_s <= '0;
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            req_m <= in_req;
            req_s <= req_m;
            ack_m <= out_ack;
            ack_s <= ack_m;
        end
    end
`else
    assign req_s = in_req;
    assign ack_s = out_ack;
`endif

    merge_in_state_t          in_state;
    merge_out_state_t         out_state;
    logic [1:0]               rr_ptr;
    logic [1:0]               cur_idx;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [1:0]               grant_idx;

    logic [N-1:0]             mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;

    rr_arbiter4 u_arb (
        .req       (req_s),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Full is judged on the pre-pop count, so a same-cycle pop never frees room for a push.
    always_comb begin
        fifo_full  = (count == CNT_W'(DEPTH));
        fifo_empty = (count == '0);
        push       = (in_state == IN_IDLE) && (req_s != '0) && !fifo_full;
        pop        = (out_state == OUT_REQ_HI) && ack_s;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= IN_IDLE;
            in_ack   <= '0;
            cur_idx  <= '0;
            rr_ptr   <= '0;
        end else begin
            case (in_state)
                IN_IDLE: begin
                    if (push) begin
                        in_ack   <= grant;
                        cur_idx  <= grant_idx;
                        rr_ptr   <= rr_advance(grant_idx);
                        in_state <= IN_ACK_HI;
                    end
                end
                IN_ACK_HI: begin
                    if (!req_s[cur_idx]) begin
                        in_ack   <= '0;
                        in_state <= IN_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= OUT_IDLE;
            out_req   <= 1'b0;
            out_data  <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (!fifo_empty) begin
                        out_data  <= mem[rd_ptr];
                        out_req   <= 1'b1;
                        out_state <= OUT_REQ_HI;
                    end
                end
                OUT_REQ_HI: begin
                    if (ack_s) begin
                        out_req   <= 1'b0;
                        out_state <= OUT_WAIT_LO;
                    end
                end
                OUT_WAIT_LO: begin
                    if (!ack_s) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: begin
                    out_req   <= 1'b0;
                    out_state <= OUT_IDLE;
                end
            endcase
        end
    end

endmodule
